// File: rtl/controle_multiciclo.sv
// controle_multiciclo: main control FSM for the multicycle MIPS datapath.
// Sequences fetch, decode, execute, memory and write-back with
// memory-ready qualification and illegal-opcode trapping.
// Optional feature: define CONTROLE_BNE_EN to decode bne (opcode 000101)
// into the branch state with BranchNE asserted.
module controle_multiciclo #(
    parameter bit ESPERA_MEM    = 1'b1,
    parameter bit TRAP_INVALIDO = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_pronta,
    output logic       PCEscreve,
    output logic       PCEscreveCond,
    output logic       IouD,
    output logic       LeMem,
    output logic       EscreveMem,
    output logic       IREscreve,
    output logic       MemparaReg,
    output logic       AluSrcA,
    output logic       EscreveReg,
    output logic       RegDst,
    output logic       BranchNE,
    output logic [1:0] PCFonte,
    output logic [1:0] AluSrcB,
    output logic [1:0] AluOp,
    output logic [3:0] estado,
    output logic       invalido
);

    typedef enum logic [3:0] {
        BUSCA        = 4'd0,
        DECODIFICA   = 4'd1,
        CALC_END     = 4'd2,
        LE_MEM       = 4'd3,
        ESCRITA_LW   = 4'd4,
        ESCREVE_MEM  = 4'd5,
        EXECUTA_R    = 4'd6,
        CONCLUI_R    = 4'd7,
        DESVIO       = 4'd8,
        SALTO        = 4'd9,
        CONCLUI_ADDI = 4'd10,
        INVALIDO     = 4'd15
    } estado_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef CONTROLE_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    estado_t r_estado;
    estado_t w_proximo;
    logic    w_pronta;

`ifdef CONTROLE_BNE_EN
    logic    r_bne;
    logic    w_bne_prox;
`endif

    // Memory handshake; with waiting disabled every access completes at once.
    assign w_pronta = ESPERA_MEM ? mem_pronta : 1'b1;

    assign estado = r_estado;

    // State register; the bne flag travels with the state into DESVIO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= BUSCA;
`ifdef CONTROLE_BNE_EN
            r_bne    <= 1'b0;
`endif
        end else begin
            r_estado <= w_proximo;
`ifdef CONTROLE_BNE_EN
            r_bne    <= w_bne_prox;
`endif
        end
    end

    // Next-state decode from the current state, opcode and memory ready.
    always_comb begin
        w_proximo = BUSCA;
`ifdef CONTROLE_BNE_EN
        w_bne_prox = 1'b0;
`endif
        case (r_estado)
            BUSCA: begin
                w_proximo = w_pronta ? DECODIFICA : BUSCA;
            end
            DECODIFICA: begin
                case (opcode)
                    OP_R:                   w_proximo = EXECUTA_R;
                    OP_LW, OP_SW, OP_ADDI:  w_proximo = CALC_END;
                    OP_BEQ:                 w_proximo = DESVIO;
                    OP_J:                   w_proximo = SALTO;
`ifdef CONTROLE_BNE_EN
                    OP_BNE: begin
                        w_proximo  = DESVIO;
                        w_bne_prox = 1'b1;
                    end
`endif
                    default: w_proximo = TRAP_INVALIDO ? INVALIDO : BUSCA;
                endcase
            end
            CALC_END: begin
                // Only lw/sw/addi reach here; anything else falls back to fetch.
                case (opcode)
                    OP_LW:   w_proximo = LE_MEM;
                    OP_SW:   w_proximo = ESCREVE_MEM;
                    OP_ADDI: w_proximo = CONCLUI_ADDI;
                    default: w_proximo = BUSCA;
                endcase
            end
            LE_MEM: begin
                w_proximo = w_pronta ? ESCRITA_LW : LE_MEM;
            end
            ESCREVE_MEM: begin
                w_proximo = w_pronta ? BUSCA : ESCREVE_MEM;
            end
            EXECUTA_R: begin
                w_proximo = CONCLUI_R;
            end
            ESCRITA_LW, CONCLUI_R, DESVIO, SALTO, CONCLUI_ADDI: begin
                w_proximo = BUSCA;
            end
            INVALIDO: begin
                w_proximo = INVALIDO;
            end
            default: begin
                w_proximo = BUSCA;
            end
        endcase
    end

    // Moore output decode; only the fetch write enables look at mem_pronta.
    always_comb begin
        PCEscreve     = 1'b0;
        PCEscreveCond = 1'b0;
        IouD          = 1'b0;
        LeMem         = 1'b0;
        EscreveMem    = 1'b0;
        IREscreve     = 1'b0;
        MemparaReg    = 1'b0;
        AluSrcA       = 1'b0;
        EscreveReg    = 1'b0;
        RegDst        = 1'b0;
        BranchNE      = 1'b0;
        PCFonte       = 2'b00;
        AluSrcB       = 2'b00;
        AluOp         = 2'b00;
        invalido      = 1'b0;
        case (r_estado)
            BUSCA: begin
                LeMem     = 1'b1;
                AluSrcB   = 2'b01;
                // Gated by reset so a held reset never writes IR or PC.
                IREscreve = w_pronta & reset_n;
                PCEscreve = w_pronta & reset_n;
            end
            DECODIFICA: begin
                AluSrcB = 2'b11;
            end
            CALC_END: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
            end
            LE_MEM: begin
                LeMem = 1'b1;
                IouD  = 1'b1;
            end
            ESCRITA_LW: begin
                EscreveReg = 1'b1;
                MemparaReg = 1'b1;
            end
            ESCREVE_MEM: begin
                EscreveMem = 1'b1;
                IouD       = 1'b1;
            end
            EXECUTA_R: begin
                AluSrcA = 1'b1;
                AluOp   = 2'b10;
            end
            CONCLUI_R: begin
                RegDst     = 1'b1;
                EscreveReg = 1'b1;
            end
            DESVIO: begin
                AluSrcA       = 1'b1;
                AluOp         = 2'b01;
                PCEscreveCond = 1'b1;
                PCFonte       = 2'b01;
`ifdef CONTROLE_BNE_EN
                BranchNE      = r_bne;
`endif
            end
            SALTO: begin
                PCEscreve = 1'b1;
                PCFonte   = 2'b10;
            end
            CONCLUI_ADDI: begin
                EscreveReg = 1'b1;
            end
            INVALIDO: begin
                invalido = 1'b1;
            end
            default: begin
                invalido = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: vector table for the instruction
// traces plus hand sequences for reset, wait states, trapping and bne.
module tb_controle_multiciclo;

    // Control vector packing:
    // {PCEscreve, PCEscreveCond, IouD, LeMem, EscreveMem, IREscreve,
    //  MemparaReg, AluSrcA, EscreveReg, RegDst, BranchNE,
    //  PCFonte[1:0], AluSrcB[1:0], AluOp[1:0], invalido}
    localparam logic [17:0] C_BUSCA_RDY = 18'b1_0_0_1_0_1_0_0_0_0_0_00_01_00_0;
    localparam logic [17:0] C_BUSCA_ESP = 18'b0_0_0_1_0_0_0_0_0_0_0_00_01_00_0;
    localparam logic [17:0] C_DECOD     = 18'b0_0_0_0_0_0_0_0_0_0_0_00_11_00_0;
    localparam logic [17:0] C_CALC      = 18'b0_0_0_0_0_0_0_1_0_0_0_00_10_00_0;
    localparam logic [17:0] C_LE_MEM    = 18'b0_0_1_1_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] C_ESC_LW    = 18'b0_0_0_0_0_0_1_0_1_0_0_00_00_00_0;
    localparam logic [17:0] C_ESC_MEM   = 18'b0_0_1_0_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] C_EXEC_R    = 18'b0_0_0_0_0_0_0_1_0_0_0_00_00_10_0;
    localparam logic [17:0] C_CONC_R    = 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [17:0] C_DESVIO    = 18'b0_1_0_0_0_0_0_1_0_0_0_01_00_01_0;
    localparam logic [17:0] C_DESVIO_NE = 18'b0_1_0_0_0_0_0_1_0_0_1_01_00_01_0;
    localparam logic [17:0] C_SALTO     = 18'b1_0_0_0_0_0_0_0_0_0_0_10_00_00_0;
    localparam logic [17:0] C_ADDI      = 18'b0_0_0_0_0_0_0_0_1_0_0_00_00_00_0;
    localparam logic [17:0] C_INVAL     = 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clock;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_pronta;

    logic       PCEscreve, PCEscreveCond, IouD, LeMem, EscreveMem, IREscreve;
    logic       MemparaReg, AluSrcA, EscreveReg, RegDst, BranchNE, invalido;
    logic [1:0] PCFonte, AluSrcB, AluOp;
    logic [3:0] estado;
    logic [17:0] ctl;

    logic [17:0] nt_ctl, nw_ctl;
    logic [3:0]  nt_estado, nw_estado;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0]  op;
        logic        pr;
        logic [3:0]  st;
        logic [17:0] c;
    } vec_t;
    vec_t tab[$];

    controle_multiciclo dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_pronta(mem_pronta),
        .PCEscreve(PCEscreve), .PCEscreveCond(PCEscreveCond), .IouD(IouD),
        .LeMem(LeMem), .EscreveMem(EscreveMem), .IREscreve(IREscreve),
        .MemparaReg(MemparaReg), .AluSrcA(AluSrcA), .EscreveReg(EscreveReg),
        .RegDst(RegDst), .BranchNE(BranchNE), .PCFonte(PCFonte),
        .AluSrcB(AluSrcB), .AluOp(AluOp), .estado(estado), .invalido(invalido)
    );

    // Non-trapping variant: unknown opcodes fall back to fetch.
    controle_multiciclo #(.ESPERA_MEM(1'b1), .TRAP_INVALIDO(1'b0)) dut_nt (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_pronta(mem_pronta),
        .PCEscreve(nt_ctl[17]), .PCEscreveCond(nt_ctl[16]), .IouD(nt_ctl[15]),
        .LeMem(nt_ctl[14]), .EscreveMem(nt_ctl[13]), .IREscreve(nt_ctl[12]),
        .MemparaReg(nt_ctl[11]), .AluSrcA(nt_ctl[10]), .EscreveReg(nt_ctl[9]),
        .RegDst(nt_ctl[8]), .BranchNE(nt_ctl[7]), .PCFonte(nt_ctl[6:5]),
        .AluSrcB(nt_ctl[4:3]), .AluOp(nt_ctl[2:1]), .estado(nt_estado),
        .invalido(nt_ctl[0])
    );

    // No-wait variant: mem_pronta is ignored.
    controle_multiciclo #(.ESPERA_MEM(1'b0), .TRAP_INVALIDO(1'b1)) dut_nw (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_pronta(mem_pronta),
        .PCEscreve(nw_ctl[17]), .PCEscreveCond(nw_ctl[16]), .IouD(nw_ctl[15]),
        .LeMem(nw_ctl[14]), .EscreveMem(nw_ctl[13]), .IREscreve(nw_ctl[12]),
        .MemparaReg(nw_ctl[11]), .AluSrcA(nw_ctl[10]), .EscreveReg(nw_ctl[9]),
        .RegDst(nw_ctl[8]), .BranchNE(nw_ctl[7]), .PCFonte(nw_ctl[6:5]),
        .AluSrcB(nw_ctl[4:3]), .AluOp(nw_ctl[2:1]), .estado(nw_estado),
        .invalido(nw_ctl[0])
    );

    assign ctl = {PCEscreve, PCEscreveCond, IouD, LeMem, EscreveMem, IREscreve,
                  MemparaReg, AluSrcA, EscreveReg, RegDst, BranchNE,
                  PCFonte, AluSrcB, AluOp, invalido};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, then check state and controls.
    task automatic apply(input logic [5:0] op, input logic pr, input logic [3:0] st,
                         input logic [17:0] c, input string nm);
        @(negedge clock);
        opcode     = op;
        mem_pronta = pr;
        #1;
        check({nm, ".estado"}, {28'd0, estado}, {28'd0, st});
        check({nm, ".ctl"}, {14'd0, ctl}, {14'd0, c});
    endtask

    // Pulse reset across one rising edge; FSM left in BUSCA before the next edge.
    task automatic pulse_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic add(input logic [5:0] op, input logic pr, input logic [3:0] st,
                       input logic [17:0] c);
        vec_t v;
        v.op = op; v.pr = pr; v.st = st; v.c = c;
        tab.push_back(v);
    endtask

    initial begin
        // add (BUSCA cycle checked by hand at reset release)
        add(OP_R, 1, 4'd1, C_DECOD);
        add(OP_R, 1, 4'd6, C_EXEC_R);
        add(OP_R, 1, 4'd7, C_CONC_R);
        // lw
        add(OP_LW, 1, 4'd0, C_BUSCA_RDY);
        add(OP_LW, 1, 4'd1, C_DECOD);
        add(OP_LW, 1, 4'd2, C_CALC);
        add(OP_LW, 1, 4'd3, C_LE_MEM);
        add(OP_LW, 1, 4'd4, C_ESC_LW);
        // sw
        add(OP_SW, 1, 4'd0, C_BUSCA_RDY);
        add(OP_SW, 1, 4'd1, C_DECOD);
        add(OP_SW, 1, 4'd2, C_CALC);
        add(OP_SW, 1, 4'd5, C_ESC_MEM);
        // addi
        add(OP_ADDI, 1, 4'd0, C_BUSCA_RDY);
        add(OP_ADDI, 1, 4'd1, C_DECOD);
        add(OP_ADDI, 1, 4'd2, C_CALC);
        add(OP_ADDI, 1, 4'd10, C_ADDI);
        // beq
        add(OP_BEQ, 1, 4'd0, C_BUSCA_RDY);
        add(OP_BEQ, 1, 4'd1, C_DECOD);
        add(OP_BEQ, 1, 4'd8, C_DESVIO);
        // j
        add(OP_J, 1, 4'd0, C_BUSCA_RDY);
        add(OP_J, 1, 4'd1, C_DECOD);
        add(OP_J, 1, 4'd9, C_SALTO);
        // lw with 3 fetch waits and 2 read waits: 10 cycles
        add(OP_LW, 0, 4'd0, C_BUSCA_ESP);
        add(OP_LW, 0, 4'd0, C_BUSCA_ESP);
        add(OP_LW, 0, 4'd0, C_BUSCA_ESP);
        add(OP_LW, 1, 4'd0, C_BUSCA_RDY);
        add(OP_LW, 1, 4'd1, C_DECOD);
        add(OP_LW, 1, 4'd2, C_CALC);
        add(OP_LW, 0, 4'd3, C_LE_MEM);
        add(OP_LW, 0, 4'd3, C_LE_MEM);
        add(OP_LW, 1, 4'd3, C_LE_MEM);
        add(OP_LW, 1, 4'd4, C_ESC_LW);
        // sw with 4 write waits: EscreveMem held 5 cycles
        add(OP_SW, 1, 4'd0, C_BUSCA_RDY);
        add(OP_SW, 1, 4'd1, C_DECOD);
        add(OP_SW, 1, 4'd2, C_CALC);
        add(OP_SW, 0, 4'd5, C_ESC_MEM);
        add(OP_SW, 0, 4'd5, C_ESC_MEM);
        add(OP_SW, 0, 4'd5, C_ESC_MEM);
        add(OP_SW, 0, 4'd5, C_ESC_MEM);
        add(OP_SW, 1, 4'd5, C_ESC_MEM);

        // Reset state, with mem_pronta high to prove fetch writes stay off.
        reset_n    = 1'b0;
        opcode     = OP_R;
        mem_pronta = 1'b1;
        #3;
        check("rst.estado", {28'd0, estado}, 32'd0);
        check("rst.ctl", {14'd0, ctl}, {14'd0, C_BUSCA_ESP});
        check("rst.nw_IREscreve", {31'd0, nw_ctl[12]}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rel.estado", {28'd0, estado}, 32'd0);
        check("rel.ctl", {14'd0, ctl}, {14'd0, C_BUSCA_RDY});

        foreach (tab[i]) apply(tab[i].op, tab[i].pr, tab[i].st, tab[i].c, "tab");

        // Reset asserted in EXECUTA_R aborts the instruction asynchronously.
        apply(OP_R, 1, 4'd0, C_BUSCA_RDY, "rmid0");
        apply(OP_R, 1, 4'd1, C_DECOD, "rmid1");
        apply(OP_R, 1, 4'd6, C_EXEC_R, "rmid6");
        #2;
        reset_n = 1'b0;
        #1;
        check("rmid.async_estado", {28'd0, estado}, 32'd0);
        check("rmid.async_ctl", {14'd0, ctl}, {14'd0, C_BUSCA_ESP});
        @(posedge clock);
        #1;
        check("rmid.hold_estado", {28'd0, estado}, 32'd0);
        mem_pronta = 1'b0;
        reset_n    = 1'b1;
        #1;
        check("nw.ire_no_wait", {31'd0, nw_ctl[12]}, 32'd1);
        check("rmid.ire_wait", {31'd0, IREscreve}, 32'd0);
        @(posedge clock);
        #1;
        check("rmid.wait_estado", {28'd0, estado}, 32'd0);
        check("nw.one_cycle_busca", {28'd0, nw_estado}, 32'd1);
        mem_pronta = 1'b1;
        @(posedge clock);
        #1;
        check("rmid.first_fetch", {28'd0, estado}, 32'd1);

        // bne: decoded only when the optional feature is built in.
        pulse_reset();
        apply(OP_BNE, 1, 4'd0, C_BUSCA_RDY, "bne0");
        apply(OP_BNE, 1, 4'd1, C_DECOD, "bne1");
`ifdef CONTROLE_BNE_EN
        apply(OP_BNE, 1, 4'd8, C_DESVIO_NE, "bne_desvio");
        apply(OP_BNE, 1, 4'd0, C_BUSCA_RDY, "bne_volta");
`else
        apply(OP_BNE, 1, 4'd15, C_INVAL, "bne_inval");
`endif

        // Illegal opcode: trapping instance locks, non-trapping one refetches.
        pulse_reset();
        apply(OP_BAD, 1, 4'd0, C_BUSCA_RDY, "bad0");
        apply(OP_BAD, 1, 4'd1, C_DECOD, "bad1");
        check("nt.decod", {28'd0, nt_estado}, 32'd1);
        for (int i = 0; i < 22; i++) begin
            apply(OP_BAD, i[0], 4'd15, C_INVAL, "bad_lock");
            if (i == 0) begin
                check("nt.volta_busca", {28'd0, nt_estado}, 32'd0);
                check("nt.ctl_busca", {14'd0, nt_ctl}, {14'd0, C_BUSCA_ESP});
            end
        end
        pulse_reset();
        apply(OP_R, 1, 4'd0, C_BUSCA_RDY, "recov0");
        apply(OP_R, 1, 4'd1, C_DECOD, "recov1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle successor of the single-cycle main control decoder. It is a Moore-style FSM with memory-ready qualification that sequences the multicycle MIPS datapath (shared memory, IR, A/B/ALUOut registers) through fetch, decode, execute, memory and write-back. It sits after the instruction register: it takes `opcode` = IR[31:26] and drives every datapath enable and mux select. It supports R-format, lw, sw, beq, addi and j, optional bne, variable-latency memory, and illegal-opcode trapping.

## Interface
- `ESPERA_MEM`, 1: 1 = memory states wait for `mem_pronta`; 0 = `mem_pronta` ignored (treated as 1).
- `TRAP_INVALIDO`, 1: 1 = unknown opcode enters INVALIDO and locks; 0 = unknown opcode returns to BUSCA (NOP).
- `clock`  in  1  sole clock; rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `opcode`  in  6  IR[31:26]; sampled only in DECODIFICA and CALC_END.
- `mem_pronta`  in  1  memory completed the access this cycle.
- `PCEscreve`, `PCEscreveCond`, `IouD`, `LeMem`, `EscreveMem`, `IREscreve`, `MemparaReg`, `AluSrcA`, `EscreveReg`, `RegDst`, `BranchNE`  out  1 each  datapath controls.
- `PCFonte`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `AluSrcB`  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- `AluOp`  out  2  00 = add, 01 = sub, 10 = funct field.
- `estado`  out  4  current state encoding.
- `invalido`  out  1  high while in INVALIDO.

## Operation
- State encodings:
  - BUSCA = 0, DECODIFICA = 1, CALC_END = 2, LE_MEM = 3, ESCRITA_LW = 4, ESCREVE_MEM = 5
  - EXECUTA_R = 6, CONCLUI_R = 7, DESVIO = 8, SALTO = 9, CONCLUI_ADDI = 10, INVALIDO = 15
  - Codes 11–14 are unreachable; if ever entered, the next state is BUSCA.
- Outputs not listed for a state are 0.
  - BUSCA: LeMem = 1, AluSrcB = 01. IREscreve = PCEscreve = `mem_pronta`.
  - DECODIFICA: AluSrcB = 11.
  - CALC_END: AluSrcA = 1, AluSrcB = 10.
  - LE_MEM: LeMem = 1, IouD = 1.
  - ESCRITA_LW: EscreveReg = 1, MemparaReg = 1.
  - ESCREVE_MEM: EscreveMem = 1, IouD = 1.
  - EXECUTA_R: AluSrcA = 1, AluOp = 10.
  - CONCLUI_R: RegDst = 1, EscreveReg = 1.
  - DESVIO: AluSrcA = 1, AluOp = 01, PCEscreveCond = 1, PCFonte = 01, BranchNE = 1 only for bne.
  - SALTO: PCEscreve = 1, PCFonte = 10.
  - CONCLUI_ADDI: EscreveReg = 1.
  - INVALIDO: all controls 0, `invalido` = 1.
- Transitions:
  - BUSCA → DECODIFICA on `mem_pronta`; otherwise stay.
  - DECODIFICA → by opcode:
    - 000000 → EXECUTA_R
    - 100011, 101011, 001000 → CALC_END
    - 000100 → DESVIO
    - 000010 → SALTO
    - other → INVALIDO or BUSCA, per TRAP_INVALIDO.
  - CALC_END → LE_MEM (lw), ESCREVE_MEM (sw), CONCLUI_ADDI (addi).
  - LE_MEM → ESCRITA_LW on `mem_pronta`; otherwise stay.
  - ESCREVE_MEM → BUSCA on `mem_pronta`; otherwise stay.
  - EXECUTA_R → CONCLUI_R.
  - ESCRITA_LW, CONCLUI_R, DESVIO, SALTO, CONCLUI_ADDI → BUSCA.
  - INVALIDO → INVALIDO until reset.
- Memory-state rule: LeMem/EscreveMem/IouD stay constant for the entire wait; EscreveMem must not pulse.
- `BranchNE` is registered with the state: set on entry to DESVIO for bne, held through DESVIO.

## Timing
- Reset (asynchronous, `reset_n` = 0):
  - State = BUSCA immediately.
  - All outputs take their BUSCA values: LeMem = 1, AluSrcB = 01, `estado` = 0, IREscreve = PCEscreve = 0 regardless of `mem_pronta`.
  - The FSM holds while `reset_n` = 0.
  - Reset asserted mid-instruction aborts with no further writes; first fetch occurs on the first rising edge after release with `mem_pronta` = 1.
- Outputs are decoded combinationally from the state register. The only input-dependent outputs are IREscreve and PCEscreve in BUSCA.
- Cycles per instruction, zero-wait memory: R = 4, lw = 5, sw = 4, addi = 4, beq = 3, j = 3. Each memory wait cycle adds 1.
- With ESPERA_MEM = 0, BUSCA/LE_MEM/ESCREVE_MEM each last exactly 1 cycle.
- `opcode` must be stable from the DECODIFICA cycle through CALC_END (IR is written only in BUSCA).

## Configuration
- `CONTROLE_BNE_EN` defined:
  - opcode 000101 → DESVIO with BranchNE = 1.
  - beq keeps BranchNE = 0.
- Not defined:
  - 000101 is an invalid opcode.
  - BranchNE is tied to 0.

## Test plan
- Reset: assert `reset_n` = 0 mid-EXECUTA_R → `estado` = 0 asynchronously, EscreveReg = 0, LeMem = 1. Release with `mem_pronta` = 1 → `estado` 1 at the next edge.
- Zero-wait sequence add, lw, sw, addi, beq, j → `estado` traces exactly as below, with the per-state outputs checked every cycle:
  - add: 0,1,6,7
  - lw: 0,1,2,3,4
  - sw: 0,1,2,5
  - addi: 0,1,2,10
  - beq: 0,1,8
  - j: 0,1,9
- Wait states: lw with `mem_pronta` low 3 cycles in BUSCA and 2 in LE_MEM → 10 cycles total. IREscreve pulses exactly once; LeMem/IouD stay 1 throughout LE_MEM.
- sw under wait: `mem_pronta` low 4 cycles in ESCREVE_MEM → EscreveMem held 1 for 5 cycles, then BUSCA.
- Invalid opcode 111111:
  - TRAP_INVALIDO = 1 → `estado` = 15, `invalido` = 1, all writes 0 for 20+ cycles, then recovery only via reset.
  - TRAP_INVALIDO = 0 → returns to BUSCA after DECODIFICA.
- bne 000101:
  - With `CONTROLE_BNE_EN` → DESVIO with BranchNE = 1, PCEscreveCond = 1, AluOp = 01.
  - Without the macro → INVALIDO.
